// File: rtl/pos_dac_spi_if.sv
// pos_dac_spi_if: position command in, SPI DAC pins and status out
interface pos_dac_spi_if;
  logic [15:0] pos_dac;
  logic        dac_update_req;
  logic        dac_sclk;
  logic        dac_csn;
  logic        dac_sdi;
  logic        dac_ldacn;
  logic        dac_busy;
  logic        dac_done;
  logic [15:0] dac_last;
  modport master (
    output pos_dac, dac_update_req,
    input  dac_sclk, dac_csn, dac_sdi, dac_ldacn, dac_busy, dac_done, dac_last
  );
  modport slave (
    input  pos_dac, dac_update_req,
    output dac_sclk, dac_csn, dac_sdi, dac_ldacn, dac_busy, dac_done, dac_last
  );
endinterface

// File: rtl/pos_dac_spi.sv
// pos_dac_spi: shifts 16-bit DAC codes MSB-first over SPI, then strobes LDAC
module pos_dac_spi #(
  parameter int CLK_DIV     = 4,
  parameter int LDAC_CYCLES = 2,
  parameter bit AUTO_UPDATE = 1'b1
) (
  input logic          clk_pid,
  input logic          sys_rstn,
  pos_dac_spi_if.slave bus
);
  typedef enum logic [2:0] {IDLE, SHIFT, HOLD, LDAC, DONE} state_e;
  localparam logic [7:0] DIV_TC  = 8'(CLK_DIV - 1);
  localparam logic [7:0] LDAC_TC = 8'(LDAC_CYCLES - 1);
  state_e      state_q, state_d;
  logic [15:0] word_q, word_d, last_q, last_d;
  logic [7:0]  div_q, div_d;
  logic [4:0]  bit_q, bit_d;
  logic        sclk_q, sclk_d, csn_q, csn_d, sdi_q, sdi_d;
  logic        ldacn_q, ldacn_d, done_q, done_d, pend_q, pend_d;
  logic        trig, div_tc, ldac_tc, fall, last_fall;
  assign trig      = bus.dac_update_req || (AUTO_UPDATE && bus.pos_dac != last_q) || pend_q;
  assign div_tc    = div_q == DIV_TC;
  assign ldac_tc   = div_q == LDAC_TC;
  assign fall      = div_tc && sclk_q;
  assign last_fall = fall && bit_q == 5'd16;
  // state and datapath registers, all cleared asynchronously
  always_ff @(posedge clk_pid or negedge sys_rstn)
    if (!sys_rstn) begin
      state_q <= IDLE;
      word_q  <= '0;
      last_q  <= 16'h8000;
      div_q   <= '0;
      bit_q   <= '0;
      sclk_q  <= 1'b0;
      csn_q   <= 1'b1;
      sdi_q   <= 1'b0;
      ldacn_q <= 1'b1;
      done_q  <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      last_q  <= last_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      sclk_q  <= sclk_d;
      csn_q   <= csn_d;
      sdi_q   <= sdi_d;
      ldacn_q <= ldacn_d;
      done_q  <= done_d;
      pend_q  <= pend_d;
    end
  // transfer sequencing: shift, CS deassert hold, LDAC strobe, done cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (trig) state_d = SHIFT;
      SHIFT:   if (last_fall) state_d = HOLD;
      HOLD:    if (div_tc) state_d = LDAC;
      LDAC:    if (ldac_tc) state_d = DONE;
      default: state_d = IDLE;
    endcase
  end
  // pin and datapath updates; sdi only moves on falling SCLK toggles
  always_comb begin
    word_d  = word_q;
    last_d  = last_q;
    div_d   = div_q;
    bit_d   = bit_q;
    sclk_d  = sclk_q;
    csn_d   = csn_q;
    sdi_d   = sdi_q;
    ldacn_d = ldacn_q;
    done_d  = 1'b0;
    pend_d  = pend_q;
    case (state_q)
      IDLE: if (trig) begin
        word_d = bus.pos_dac;
        csn_d  = 1'b0;
        sdi_d  = bus.pos_dac[15];
        div_d  = '0;
        bit_d  = '0;
        pend_d = 1'b0;
      end
      SHIFT: begin
        div_d  = div_tc ? 8'd0 : div_q + 8'd1;
        sclk_d = div_tc ? ~sclk_q : sclk_q;
        bit_d  = (div_tc && !sclk_q) ? bit_q + 5'd1 : bit_q;
        if (fall) begin
          csn_d = last_fall;
          sdi_d = last_fall ? 1'b0 : word_q[4'(5'd15 - bit_q)];
        end
      end
      HOLD: begin
        div_d   = div_tc ? 8'd0 : div_q + 8'd1;
        ldacn_d = !div_tc;
      end
      LDAC: begin
        div_d   = div_q + 8'd1;
        ldacn_d = ldac_tc;
        done_d  = ldac_tc;
        last_d  = ldac_tc ? word_q : last_q;
      end
      default: ;
    endcase
    if (state_q != IDLE && bus.dac_update_req) pend_d = 1'b1;
  end
  assign bus.dac_sclk  = sclk_q;
  assign bus.dac_csn   = csn_q;
  assign bus.dac_sdi   = sdi_q;
  assign bus.dac_ldacn = ldacn_q;
  assign bus.dac_busy  = state_q != IDLE;
  assign bus.dac_done  = done_q;
  assign bus.dac_last  = last_q;
endmodule

// File: tb/tb_pos_dac_spi.sv
// tb_pos_dac_spi: directed and random checks of pos_dac_spi against a pin-level SPI decoder
module tb_pos_dac_spi;
  localparam int D0 = 4, D1 = 1, LD = 2;
  logic clk_pid = 1'b0;
  logic sys_rstn = 1'b0;
  always #5 clk_pid = ~clk_pid;
  pos_dac_spi_if b0 ();
  pos_dac_spi_if b1 ();
  pos_dac_spi #(.CLK_DIV(D0), .LDAC_CYCLES(LD)) u0 (.clk_pid(clk_pid), .sys_rstn(sys_rstn), .bus(b0));
  pos_dac_spi #(.CLK_DIV(D1), .LDAC_CYCLES(LD)) u1 (.clk_pid(clk_pid), .sys_rstn(sys_rstn), .bus(b1));
  int cyc = 0, errs = 0, checks = 0, t0 = 0;
  int xfers[2], dones[2], sdi_bad[2], fall_c[2], rise_c[2], sclk1_c[2], ldac_c[2], ldac_len[2], done_c[2], nb[2], nbl[2];
  logic [1:0] done_busy;
  logic [15:0] sh[2];
  logic [15:0] w0[$], w1[$];
  logic [15:0] exp_last, v;
  logic [1:0] s_sclk, s_sdi, s_csn, s_ldacn, s_done, s_busy;
  logic [1:0] p_sclk = '0, p_sdi = '0, p_csn = '1, p_ldacn = '1;
  assign s_sclk  = {b1.dac_sclk, b0.dac_sclk};
  assign s_sdi   = {b1.dac_sdi, b0.dac_sdi};
  assign s_csn   = {b1.dac_csn, b0.dac_csn};
  assign s_ldacn = {b1.dac_ldacn, b0.dac_ldacn};
  assign s_done  = {b1.dac_done, b0.dac_done};
  assign s_busy  = {b1.dac_busy, b0.dac_busy};
  always @(posedge clk_pid) cyc <= cyc + 1;
  // decode the SPI pins as the DAC would see them, mid-cycle
  always @(negedge clk_pid) begin
    for (int i = 0; i < 2; i++) begin
      if (p_csn[i] && !s_csn[i]) begin
        fall_c[i] <= cyc;
        xfers[i]  <= xfers[i] + 1;
      end
      if (!p_sclk[i] && s_sclk[i] && !s_csn[i]) begin
        if (nb[i] == 0) sclk1_c[i] <= cyc;
        sh[i] <= {sh[i][14:0], s_sdi[i]};
        nb[i] <= nb[i] + 1;
        if (s_sdi[i] !== p_sdi[i]) sdi_bad[i] <= sdi_bad[i] + 1;
      end else if (p_csn[i] && !s_csn[i]) begin
        sh[i] <= '0;
        nb[i] <= 0;
      end
      if (!p_csn[i] && s_csn[i]) begin
        rise_c[i] <= cyc;
        nbl[i]    <= nb[i];
        if (i == 0) w0.push_back(sh[i]);
        else w1.push_back(sh[i]);
      end
      if (p_ldacn[i] && !s_ldacn[i]) ldac_c[i] <= cyc;
      if (!s_ldacn[i]) ldac_len[i] <= ldac_len[i] + 1;
      if (s_done[i]) begin
        done_c[i]    <= cyc;
        dones[i]     <= dones[i] + 1;
        done_busy[i] <= s_busy[i];
      end
    end
    p_sclk  <= s_sclk;
    p_sdi   <= s_sdi;
    p_csn   <= s_csn;
    p_ldacn <= s_ldacn;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge clk_pid);
    #1;
  endtask
  task automatic clr();
    for (int i = 0; i < 2; i++) begin
      xfers[i] = 0;
      dones[i] = 0;
      sdi_bad[i] = 0;
      ldac_len[i] = 0;
    end
    w0.delete();
    w1.delete();
  endtask
  task automatic wait_dones(input int i, input int n, input int lim, input string tag);
    int k = 0;
    while (dones[i] < n && k < lim) begin
      tick(1);
      k++;
    end
    tick(1);
    chk(tag, dones[i], n);
  endtask
  task automatic pulse();
    b0.dac_update_req = 1'b1;
    tick(1);
    b0.dac_update_req = 1'b0;
  endtask
  function automatic logic [15:0] wd(input int i, input int k);
    if (i == 0) return (k < w0.size()) ? w0[k] : 16'hxxxx;
    return (k < w1.size()) ? w1[k] : 16'hxxxx;
  endfunction
  initial begin
    b0.pos_dac = 16'h8000;
    b0.dac_update_req = 1'b0;
    b1.pos_dac = 16'h8000;
    b1.dac_update_req = 1'b0;
    exp_last = 16'h8000;
    tick(3);
    chk("rst_csn", b0.dac_csn, 1);
    chk("rst_sclk", b0.dac_sclk, 0);
    chk("rst_sdi", b0.dac_sdi, 0);
    chk("rst_ldacn", b0.dac_ldacn, 1);
    chk("rst_busy", b0.dac_busy, 0);
    chk("rst_done", b0.dac_done, 0);
    chk("rst_last", b0.dac_last, 16'h8000);
    clr();
    sys_rstn = 1'b1;
    tick(200);
    chk("idle_xfers", xfers[0], 0);
    chk("idle_xfers1", xfers[1], 0);
    chk("idle_csn", b0.dac_csn, 1);
    chk("idle_last", b0.dac_last, 16'h8000);
    clr();
    b0.pos_dac = 16'hA5C3;
    t0 = cyc;
    wait_dones(0, 1, 400, "single_done_cnt");
    chk("single_word", wd(0, 0), 16'hA5C3);
    chk("single_bits", nbl[0], 16);
    chk("single_csn_fall", fall_c[0], t0 + 1);
    chk("single_sclk_rise0", sclk1_c[0], t0 + 1 + D0);
    chk("single_csn_rise", rise_c[0], t0 + 1 + 32 * D0);
    chk("single_ldac_start", ldac_c[0], t0 + 1 + 33 * D0);
    chk("single_ldac_len", ldac_len[0], LD);
    chk("single_done_cyc", done_c[0], t0 + 1 + 33 * D0 + LD);
    chk("single_done_busy", done_busy[0], 1);
    chk("single_sdi_stable", sdi_bad[0], 0);
    chk("single_last", b0.dac_last, 16'hA5C3);
    chk("single_idle_busy", b0.dac_busy, 0);
    clr();
    b0.pos_dac = 16'h1234;
    t0 = cyc;
    tick(40);
    b0.pos_dac = 16'hFFFF;
    wait_dones(0, 2, 600, "mid_done_cnt");
    chk("mid_word0", wd(0, 0), 16'h1234);
    chk("mid_word1", wd(0, 1), 16'hFFFF);
    chk("mid_second_start", fall_c[0], t0 + 137);
    chk("mid_last", b0.dac_last, 16'hFFFF);
    clr();
    b0.pos_dac = 16'h8000;
    wait_dones(0, 1, 400, "force_pre_done");
    chk("force_pre_last", b0.dac_last, 16'h8000);
    clr();
    t0 = cyc;
    pulse();
    tick(19);
    pulse();
    tick(19);
    pulse();
    tick(19);
    pulse();
    wait_dones(0, 2, 600, "force_done_cnt");
    tick(300);
    chk("force_total_xfers", xfers[0], 2);
    chk("force_total_dones", dones[0], 2);
    chk("force_word0", wd(0, 0), 16'h8000);
    chk("force_word1", wd(0, 1), 16'h8000);
    chk("force_second_start", fall_c[0], t0 + 137);
    exp_last = 16'h8000;
    for (int n = 0; n < 6; n++) begin
      clr();
      if ($urandom_range(0, 2) == 0) begin
        v = exp_last;
        pulse();
      end else begin
        v = 16'($urandom);
        if (v == exp_last) v = ~v;
        b0.pos_dac = v;
      end
      wait_dones(0, 1, 400, "rnd_done_cnt");
      chk("rnd_word", wd(0, 0), v);
      chk("rnd_last", b0.dac_last, v);
      exp_last = v;
    end
    v = 16'($urandom);
    if (v == exp_last || v == 16'h8000) v = v ^ 16'h0101;
    if (v == exp_last || v == 16'h8000) v = v ^ 16'h1010;
    clr();
    b0.pos_dac = v;
    tick(60);
    sys_rstn = 1'b0;
    #1;
    chk("mrst_csn", b0.dac_csn, 1);
    chk("mrst_sclk", b0.dac_sclk, 0);
    chk("mrst_sdi", b0.dac_sdi, 0);
    chk("mrst_ldacn", b0.dac_ldacn, 1);
    chk("mrst_busy", b0.dac_busy, 0);
    chk("mrst_last", b0.dac_last, 16'h8000);
    tick(2);
    clr();
    sys_rstn = 1'b1;
    wait_dones(0, 1, 400, "mrst_done_cnt");
    chk("mrst_word", wd(0, 0), v);
    chk("mrst_bits", nbl[0], 16);
    chk("mrst_last_after", b0.dac_last, v);
    v = 16'($urandom);
    if (v == 16'h8000) v = 16'h7FFF;
    clr();
    b1.pos_dac = v;
    t0 = cyc;
    wait_dones(1, 1, 200, "div1_done_cnt");
    chk("div1_word", wd(1, 0), v);
    chk("div1_bits", nbl[1], 16);
    chk("div1_csn_fall", fall_c[1], t0 + 1);
    chk("div1_csn_low", rise_c[1] - fall_c[1], 32);
    chk("div1_sclk_rise0", sclk1_c[1], t0 + 2);
    chk("div1_done_cyc", done_c[1], t0 + 1 + 33 * D1 + LD);
    chk("div1_sdi_stable", sdi_bad[1], 0);
    chk("div1_last", b1.dac_last, v);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
